// File: rtl/alu_op_executor.sv
// alu_op_executor: executes a decoded 4-bit ALU operation on two operands.
// Logic, add and move operations finish in one cycle. MULT and SQU run an
// iterative shift-add multiplier that consumes one multiplier bit per cycle.
// Results are handed to writeback through a start/ready/done handshake.
// Optional build macro: ALU_EXEC_EARLY_TERMINATE_EN. When defined, the
// multiplier stops as soon as no set multiplier bits remain. Results are the
// same in both builds; only the latency changes.
module alu_op_executor #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            ALUOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  illegal
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_MOV  = 4'b0100;
    localparam logic [3:0] OP_SQU  = 4'b0101;
    localparam logic [3:0] OP_MULT = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   acc_reg;
    logic [DATA_WIDTH-1:0]   mcand_reg;
    logic [DATA_WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]        count_reg;

    logic [DATA_WIDTH-1:0]   single_result;
    logic                    single_illegal;
    logic                    is_mul;
    logic [DATA_WIDTH-1:0]   acc_next;

    // ready is a pure decode of the state so the decode stage sees it at once
    assign ready = (state_reg == IDLE);

    // Result of the single-cycle operations, taken straight from the inputs
    // because they complete on the same edge that accepts the request
    always_comb begin
        single_result  = '0;
        single_illegal = 1'b0;
        is_mul         = 1'b0;
        case (ALUOperation)
            OP_AND:  single_result = A & B;
            OP_OR:   single_result = A | B;
            OP_NOR:  single_result = ~(A | B);
            OP_ADD:  single_result = A + B;
            OP_MOV:  single_result = B;
            OP_SQU,
            OP_MULT: is_mul = 1'b1;
            default: single_illegal = 1'b1;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    end

    // Control FSM with registered result, flags and multiplier datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            ALUResult  <= '0;
            Zero       <= 1'b1;
            illegal    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state_reg  <= MUL;
                            acc_reg    <= '0;
                            mcand_reg  <= A;
                            mplier_reg <= (ALUOperation == OP_SQU) ? A : B;
                            count_reg  <= '0;
                        end else begin
                            state_reg <= DONE;
                            ALUResult <= single_result;
                            Zero      <= (single_result == '0);
                            illegal   <= single_illegal;
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
`ifdef ALU_EXEC_EARLY_TERMINATE_EN
                    // No set bits left: the accumulator already holds the product
                    if (mplier_reg == '0) begin
                        state_reg <= DONE;
                        ALUResult <= acc_reg;
                        Zero      <= (acc_reg == '0);
                        illegal   <= 1'b0;
                        done      <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                        count_reg  <= count_reg + CNT_W'(1);
                        if (count_reg == LAST_COUNT) begin
                            state_reg <= DONE;
                            ALUResult <= acc_next;
                            Zero      <= (acc_next == '0);
                            illegal   <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start seen here is dropped, not queued
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_executor.sv
// Self-checking bench for alu_op_executor (DATA_WIDTH=32).
// Expected values come from a behavioural model using plain arithmetic.
// Honours ALU_EXEC_EARLY_TERMINATE_EN for the expected multiply latency.
module tb_alu_op_executor;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    alu_op_executor #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOperation (alu_op),
        .A            (a_in),
        .B            (b_in),
        .ready        (ready),
        .done         (done),
        .ALUResult    (result),
        .Zero         (zero),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {illegal, result} from the operation definitions
    function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        case (op)
            4'd0: return {1'b0, a & b};
            4'd1: return {1'b0, a | b};
            4'd2: return {1'b0, ~(a | b)};
            4'd3: return {1'b0, 32'((longint'(a) + longint'(b)) % (64'd1 << 32))};
            4'd4: return {1'b0, b};
            4'd5: begin p = longint'(a) * longint'(a); return {1'b0, p[31:0]}; end
            4'd6: begin p = longint'(a) * longint'(b); return {1'b0, p[31:0]}; end
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Edges after the accepting edge until done is seen
    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int len;
        if (op != 4'd5 && op != 4'd6) return 0;
`ifdef ALU_EXEC_EARLY_TERMINATE_EN
        m = (op == 4'd5) ? a : b;
        len = 0;
        for (int i = 0; i < 32; i++) if (m[i]) len = i + 1;
        return (len + 1 > 32) ? 32 : len + 1;
`else
        m = a ^ b;
        len = 32 + (m == m ? 0 : 1);
        return len;
`endif
    endfunction

    // Stimulus: wait for ready, issue one request, scramble the inputs after the
    // accepting edge, then follow the operation to done and one cycle beyond
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic zr, output logic il,
                         output int lat, output bit ready_leak,
                         output logic done_after, output logic ready_after);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        start = 1'b1; alu_op = op; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; alu_op = 4'($urandom); a_in = ~a; b_in = $urandom;
        lat = 0;
        ready_leak = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (ready !== 1'b0) ready_leak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (ready !== 1'b0) ready_leak = 1'b1;
        res = result; zr = zero; il = illegal;
        @(posedge clk); #1;
        done_after = done; ready_after = ready;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; alu_op = 4'd0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b result=%h zero=%b illegal=%b, required 1 0 00000000 1 0",
                     ready, done, result, zero, illegal);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b done=%b, required 1 0", ready, done);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [11] = '{4'd3, 4'd2, 4'd4, 4'd1, 4'd6, 4'd6, 4'd5, 4'd9, 4'd0, 4'd6, 4'd6};
        logic [31:0] as  [11] = '{32'hFFFF_FFFF, 32'd0, 32'hDEAD, 32'hF0, 32'd7, 32'h10000, 32'd12, 32'd5, 32'hC, 32'd3, 32'h1234};
        logic [31:0] bs  [11] = '{32'd1, 32'd0, 32'h1234, 32'h0F, 32'd6, 32'h10000, 32'd99, 32'd6, 32'hA, 32'd5, 32'd0};
        logic [31:0] res; logic zr, il, da, ra; int lat; bit leak;
        logic [32:0] exp;
        int elat;
        for (int i = 0; i < 11; i++) begin
            exp  = model(ops[i], as[i], bs[i]);
            elat = exp_lat(ops[i], as[i], bs[i]);
            issue(ops[i], as[i], bs[i], res, zr, il, lat, leak, da, ra);
            checks++;
            if (res !== exp[31:0] || zr !== (exp[31:0] == 32'd0) || il !== exp[32] || lat !== elat) begin
                errors++;
                $display("FAIL directed_%0d op=%b: result=%h zero=%b illegal=%b lat=%0d, required %h %b %b %0d",
                         i, ops[i], res, zr, il, lat, exp[31:0], exp[31:0] == 32'd0, exp[32], elat);
            end
            checks++;
            if (leak || da !== 1'b0 || ra !== 1'b1) begin
                errors++;
                $display("FAIL directed_hs_%0d: ready_high_while_busy=%b done_after=%b ready_after=%b, required 0 0 1",
                         i, leak, da, ra);
            end
            $display("directed op=%b A=%h B=%h -> result=%h illegal=%b lat=%0d", ops[i], as[i], bs[i], res, il, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b; logic zr, il, da, ra; int lat; bit leak;
        logic [3:0] op;
        logic [32:0] exp;
        int elat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            exp  = model(op, a, b);
            elat = exp_lat(op, a, b);
            issue(op, a, b, res, zr, il, lat, leak, da, ra);
            checks++;
            if (res !== exp[31:0] || zr !== (exp[31:0] == 32'd0) || il !== exp[32] || lat !== elat
                || leak || da !== 1'b0 || ra !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d op=%b A=%h B=%h: result=%h zero=%b illegal=%b lat=%0d leak=%b done_after=%b, required %h %b %b %0d 0 0",
                         i, op, a, b, res, zr, il, lat, leak, da, exp[31:0], exp[31:0] == 32'd0, exp[32], elat);
            end
            $display("random op=%b A=%h B=%h -> result=%h lat=%0d", op, a, b, res, lat);
        end
    endtask

    task automatic test_handshake();
        int pulses;
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        start = 1'b1; alu_op = 4'd6; a_in = 32'd11; b_in = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; alu_op = 4'd4; b_in = 32'h77;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 1 || result !== 32'd143) begin
            errors++;
            $display("FAIL handshake_ignore: done_pulses=%0d result=%h, required 1 0000008f", pulses, result);
        end
        $display("handshake start-during-MUL -> pulses=%0d result=%h", pulses, result);
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        start = 1'b1; alu_op = 4'd3; a_in = 32'd3; b_in = 32'd4;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== ((i % 2) == 0) || (done === 1'b1 && result !== 32'd7)) begin
                errors++;
                $display("FAIL back_to_back_%0d: done=%b result=%h, required done=%b result=00000007",
                         i, done, result, (i % 2) == 0);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        $display("back_to_back ADD 3+4 held start -> 2-cycle issue interval");
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] res; logic zr, il, da, ra; int lat; bit leak;
        int pulses;
        issue(4'd4, 32'd0, 32'h55, res, zr, il, lat, leak, da, ra);
        start = 1'b1; alu_op = 4'd6; a_in = 32'd9; b_in = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mul: ready=%b done=%b result=%h zero=%b, required 1 0 00000000 1",
                     ready, done, result, zero);
        end
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_done: done_pulses=%0d result=%h, required 0 00000000", pulses, result);
        end
        $display("reset mid-MUL -> aborted, pulses after release=%0d", pulses);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_executor.md
Name: alu_op_executor

Overview:
- Consumer side of the 4-bit ALUOperation code produced by the ALU control decoder.
- Executes the decoded operation on two operands:
  - Logic, add and move operations complete in a single cycle.
  - MULT and SQU use an iterative shift-add multiplier that processes one bit per cycle.
- Sits between the decode stage and writeback in the multicycle datapath, using a start/done handshake.

Parameters:
DATA_WIDTH, 32, operand and result width; the MULT/SQU iteration count equals DATA_WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only while ready=1
ALUOperation  input  4  operation code from ALU control
A  input  DATA_WIDTH  operand A
B  input  DATA_WIDTH  operand B
ready  output  1  high in IDLE only
done  output  1  one-cycle completion pulse
ALUResult  output  DATA_WIDTH  registered result; holds until the next completion
Zero  output  1  registered; equals (ALUResult==0)
illegal  output  1  registered; set on completion of an undefined code

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ALUResult=0, Zero=1, done=0, illegal=0, accumulator/multiplier/counter=0, ready=1. Reset mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, MUL, DONE. ready = (state==IDLE), combinational from state.
- IDLE, start=1 at edge k: operands and code are captured.
  - Single-cycle ops go to DONE at edge k with ALUResult loaded.
  - 0110/0101 go to MUL at edge k; acc=0, mcand=A, mplier=B (MULT) or A (SQU), count=0.
- Code map:
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 NOR: ~(A|B)
  - 0011 ADD: A+B, modulo 2^DATA_WIDTH, carry discarded
  - 0100 MOV: B
  - 0101 SQU: A*A
  - 0110 MULT: A*B
  - MULT and SQU results are the low DATA_WIDTH bits of the product.
  - Any other code (including 1001): ALUResult=0, illegal=1, single-cycle.
- MUL, each edge:
  - if mplier[0], acc += mcand
  - mcand <<= 1; mplier >>= 1; count++
  - The edge processing count==DATA_WIDTH-1 loads ALUResult=acc(final) and moves to DONE. MUL therefore lasts exactly DATA_WIDTH edges, and done is high from edge k+DATA_WIDTH.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start during MUL or DONE is ignored (not queued).
- illegal and Zero update only on the completion edge; illegal is cleared on any legal completion.
- Back-to-back: start held high re-launches on the first IDLE cycle, so the minimum issue interval is 2 cycles for single-cycle ops.
- A/B/ALUOperation changes after edge k do not affect the operation in flight.

Optional Feature:
- Macro: ALU_EXEC_EARLY_TERMINATE_EN.
- Defined: at each MUL edge, if mplier==0 the block loads ALUResult=acc and moves to DONE instead of iterating. Examples: B=0 finishes at edge k+1; B=5 finishes at edge k+4.
- Undefined: MUL always runs exactly DATA_WIDTH edges, independent of operand values.
- Results are identical in both builds; only latency differs.

Test Plan:
- Reset: assert reset=0 mid-MUL -> ready=1, done=0, ALUResult=0, Zero=1 immediately; no done after release.
- Single-cycle ops: ADD A=0xFFFFFFFF B=1 -> ALUResult=0, Zero=1, done at edge k. NOR A=0 B=0 -> 0xFFFFFFFF. MOV B=0x1234 -> 0x1234. OR 0xF0|0x0F -> 0xFF.
- MULT A=7 B=6 -> ALUResult=42 with done at edge k+32 (without macro); ready low for edges k..k+32. MULT 0x10000*0x10000 -> 0 (truncated), Zero=1.
- SQU A=12, B=99 -> 144. Changing A at edge k+1 leaves the result at 144.
- Illegal code 1001 -> ALUResult=0, illegal=1, done at edge k. Next legal AND 0xC&0xA -> 8, illegal=0.
- Handshake: pulse start during MUL -> ignored, exactly one done pulse. With ALU_EXEC_EARLY_TERMINATE_EN: MULT B=5 A=3 -> 15 at edge k+4; B=0 -> 0 at edge k+1.
